// File: rtl/srio_pkg.sv
// Shared SRIO logical-layer definitions: NWRITE type codes, HELLO header
// field positions and the initiator state encoding.
package srio_pkg;

    localparam logic [3:0] FTYPE_NWRITE = 4'h5;
    localparam logic [3:0] TTYPE_NWRITE = 4'h4;

    localparam int HDR_TID_LSB   = 56;
    localparam int HDR_FTYPE_LSB = 52;
    localparam int HDR_TTYPE_LSB = 48;
    localparam int HDR_PRIO_LSB  = 45;
    localparam int HDR_CRF_BIT   = 44;
    localparam int HDR_SIZE_LSB  = 36;
    localparam int HDR_ADDR_LSB  = 0;

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        DATA,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/srio_hello_hdr.sv
// Combinational HELLO-format header packer shared by the request initiators.
module srio_hello_hdr
    import srio_pkg::*;
(
    input  logic [7:0]  tid,
    input  logic [3:0]  ftype,
    input  logic [3:0]  ttype,
    input  logic [1:0]  prio,
    input  logic        crf,
    input  logic [7:0]  size,
    input  logic [33:0] addr,
    output logic [63:0] hdr
);

    // Unlisted bits ([47] and [35:34]) stay zero.
    always_comb begin
        hdr = '0;
        hdr[HDR_TID_LSB   +: 8]  = tid;
        hdr[HDR_FTYPE_LSB +: 4]  = ftype;
        hdr[HDR_TTYPE_LSB +: 4]  = ttype;
        hdr[HDR_PRIO_LSB  +: 2]  = prio;
        hdr[HDR_CRF_BIT]         = crf;
        hdr[HDR_SIZE_LSB  +: 8]  = size;
        hdr[HDR_ADDR_LSB  +: 34] = addr;
    end

endmodule

// File: rtl/srio_nwr_packetizer.sv
// Splits a user NWRITE stream into HELLO NWRITE packets of at most
// MAX_PAYLOAD bytes on the ireq AXI-Stream port, one header beat per packet.
module srio_nwr_packetizer
    import srio_pkg::*;
#(
    parameter int          MAX_PAYLOAD = 256,
    parameter logic [1:0]  PRIO        = 2'd1,
    parameter logic        CRF         = 1'b0,
    parameter logic [15:0] SRC_ID      = 16'h0000,
    parameter logic [15:0] DEST_ID     = 16'h0000
) (
    input  logic        log_clk,
    input  logic        log_rst_n,
    input  logic        link_ok_i,
    output logic        nwr_ready_o,
    output logic        nwr_busy_o,
    output logic        nwr_done_o,
    output logic        nwr_err_o,
    input  logic [33:0] user_addr_i,
    input  logic [19:0] user_tsize_i,
    input  logic [63:0] user_tdata_i,
    input  logic [7:0]  user_tkeep_i,
    input  logic        user_tfirst_i,
    input  logic        user_tvalid_i,
    input  logic        user_tlast_i,
    output logic        user_tready_o,
    output logic [63:0] ireq_tdata_o,
    output logic [7:0]  ireq_tkeep_o,
    output logic        ireq_tlast_o,
    output logic [31:0] ireq_tuser_o,
    output logic        ireq_tvalid_o,
    input  logic        ireq_tready_i
);

    state_t state, next_state;

    logic [33:0] addr;
    logic [20:0] rem;
    logic [7:0]  tid;
    logic [5:0]  beat_cnt;
    logic        err;

    logic [8:0]  pkt_bytes;
    logic [5:0]  pkt_beats;
    logic [7:0]  hdr_size;
    logic [63:0] hdr;
    logic        start;
    logic        xfer;
    logic        pkt_end;
    logic        final_pkt;
    logic        last_out;
    logic        pkt_done;

    assign pkt_bytes = (rem > 21'(MAX_PAYLOAD)) ? 9'(MAX_PAYLOAD) : rem[8:0];
    assign pkt_beats = 6'((pkt_bytes + 9'd7) >> 3);
    assign hdr_size  = 8'(pkt_bytes - 9'd1);

    assign start     = user_tvalid_i && user_tfirst_i && link_ok_i;
    assign xfer      = user_tvalid_i && ireq_tready_i;
    assign pkt_end   = (beat_cnt == pkt_beats - 6'd1);
    // The transfer is exhausted only when this packet carries every remaining byte.
    assign final_pkt = pkt_end && (rem == 21'(pkt_bytes));
    assign last_out  = pkt_end || user_tlast_i;
    assign pkt_done  = (state == DATA) && xfer && last_out;

    srio_hello_hdr u_hdr (
        .tid   (tid),
        .ftype (FTYPE_NWRITE),
        .ttype (TTYPE_NWRITE),
        .prio  (PRIO),
        .crf   (CRF),
        .size  (hdr_size),
        .addr  (addr),
        .hdr   (hdr)
    );

    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = HDR;
            HDR:     if (ireq_tready_i) next_state = DATA;
            DATA: begin
                if (pkt_done) begin
                    if (user_tlast_i) begin
                        next_state = DONE;
                    end else if (final_pkt) begin
                        next_state = DRAIN;
                    end else begin
                        next_state = HDR;
                    end
                end
            end
            DRAIN:   if (user_tvalid_i && user_tlast_i) next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // A length/tlast disagreement is flagged for exactly one cycle after the closing beat.
    always_ff @(posedge log_clk or negedge log_rst_n) begin
        if (!log_rst_n) begin
            addr     <= '0;
            rem      <= '0;
            tid      <= '0;
            beat_cnt <= '0;
            err      <= 1'b0;
        end else begin
            err <= pkt_done && (user_tlast_i != final_pkt);
            if (state == IDLE && start) begin
                addr     <= user_addr_i;
                rem      <= {1'b0, user_tsize_i} + 21'd1;
                beat_cnt <= '0;
            end else if (state == DATA && xfer) begin
                if (last_out) begin
                    rem      <= rem - 21'(pkt_bytes);
                    addr     <= addr + 34'(pkt_bytes);
                    tid      <= tid + 8'd1;
                    beat_cnt <= '0;
                end else begin
                    beat_cnt <= beat_cnt + 6'd1;
                end
            end
        end
    end

    always_comb begin
        nwr_ready_o   = 1'b0;
        nwr_busy_o    = 1'b0;
        nwr_done_o    = 1'b0;
        user_tready_o = 1'b0;
        ireq_tdata_o  = '0;
        ireq_tkeep_o  = '0;
        ireq_tlast_o  = 1'b0;
        ireq_tuser_o  = '0;
        ireq_tvalid_o = 1'b0;
        case (state)
            IDLE: nwr_ready_o = link_ok_i;
            HDR: begin
                nwr_busy_o    = 1'b1;
                ireq_tvalid_o = 1'b1;
                ireq_tdata_o  = hdr;
                ireq_tkeep_o  = 8'hff;
                ireq_tuser_o  = {SRC_ID, DEST_ID};
            end
            DATA: begin
                nwr_busy_o    = 1'b1;
                ireq_tvalid_o = user_tvalid_i;
                user_tready_o = ireq_tready_i;
                ireq_tdata_o  = user_tdata_i;
                ireq_tkeep_o  = user_tkeep_i;
                ireq_tlast_o  = last_out;
            end
            DRAIN: begin
                nwr_busy_o    = 1'b1;
                user_tready_o = 1'b1;
            end
            DONE:    nwr_done_o = 1'b1;
            default: ;
        endcase
    end

    assign nwr_err_o = err;

endmodule

// File: tb/tb_srio_nwr_packetizer.sv
// Scoreboard bench for srio_nwr_packetizer: a packet-level reference model
// queues expected ireq beats, a monitor pops and compares them as they leave.
`timescale 1ns/1ps
module tb_srio_nwr_packetizer;

    localparam int          MAXP = 256;
    localparam logic [1:0]  PRIO = 2'd2;
    localparam logic        CRF  = 1'b1;
    localparam logic [15:0] SRC  = 16'h1234;
    localparam logic [15:0] DST  = 16'hABCD;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic        hdr;
    } beat_t;

    logic        log_clk = 1'b0;
    logic        log_rst_n = 1'b0;
    logic        link_ok_i = 1'b0;
    logic        nwr_ready_o, nwr_busy_o, nwr_done_o, nwr_err_o;
    logic [33:0] user_addr_i = '0;
    logic [19:0] user_tsize_i = '0;
    logic [63:0] user_tdata_i = '0;
    logic [7:0]  user_tkeep_i = '0;
    logic        user_tfirst_i = 1'b0;
    logic        user_tvalid_i = 1'b0;
    logic        user_tlast_i = 1'b0;
    logic        user_tready_o;
    logic [63:0] ireq_tdata_o;
    logic [7:0]  ireq_tkeep_o;
    logic        ireq_tlast_o;
    logic [31:0] ireq_tuser_o;
    logic        ireq_tvalid_o;
    logic        ireq_tready_i = 1'b0;

    int          n_checks = 0;
    int          n_passed = 0;
    int          done_count = 0;
    int          err_count = 0;
    int          exp_done = 0;
    int          exp_err = 0;
    logic [7:0]  model_tid = 8'd0;
    bit          rdy_random = 1'b0;
    bit          valid_gaps = 1'b0;
    beat_t       exp_q[$];
    logic [63:0] s_data[$];
    logic [7:0]  s_keep[$];

    srio_nwr_packetizer #(
        .MAX_PAYLOAD (MAXP),
        .PRIO        (PRIO),
        .CRF         (CRF),
        .SRC_ID      (SRC),
        .DEST_ID     (DST)
    ) dut (
        .log_clk       (log_clk),
        .log_rst_n     (log_rst_n),
        .link_ok_i     (link_ok_i),
        .nwr_ready_o   (nwr_ready_o),
        .nwr_busy_o    (nwr_busy_o),
        .nwr_done_o    (nwr_done_o),
        .nwr_err_o     (nwr_err_o),
        .user_addr_i   (user_addr_i),
        .user_tsize_i  (user_tsize_i),
        .user_tdata_i  (user_tdata_i),
        .user_tkeep_i  (user_tkeep_i),
        .user_tfirst_i (user_tfirst_i),
        .user_tvalid_i (user_tvalid_i),
        .user_tlast_i  (user_tlast_i),
        .user_tready_o (user_tready_o),
        .ireq_tdata_o  (ireq_tdata_o),
        .ireq_tkeep_o  (ireq_tkeep_o),
        .ireq_tlast_o  (ireq_tlast_o),
        .ireq_tuser_o  (ireq_tuser_o),
        .ireq_tvalid_o (ireq_tvalid_o),
        .ireq_tready_i (ireq_tready_i)
    );

    always #5 log_clk = ~log_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic failNow(input string name);
        n_checks++;
        $display("[TB] FAIL %s", name);
    endtask

    function automatic logic [63:0] mkHdr(input logic [7:0] t, input int pb, input logic [33:0] a);
        logic [7:0] sz;
        sz = 8'(pb - 1);
        return {t, 4'h5, 4'h4, 1'b0, PRIO, CRF, sz, 2'b00, a};
    endfunction

    // Packet-level model: walk the declared length in MAX_PAYLOAD slices and
    // stop at whichever of the declared length or the user stream ends first.
    task automatic modelTransfer(input logic [33:0] base, input int bytes, input int n_stream);
        int          rem;
        int          pb;
        int          nb;
        int          idx;
        bit          err;
        bit          ended;
        bit          user_last;
        bit          last;
        logic [33:0] a;
        rem = bytes;
        a = base;
        idx = 0;
        err = 1'b0;
        ended = 1'b0;
        while (!ended) begin
            pb = (rem < MAXP) ? rem : MAXP;
            nb = (pb + 7) / 8;
            exp_q.push_back('{mkHdr(model_tid, pb, a), 8'hff, 1'b0, 1'b1});
            for (int k = 0; k < nb; k++) begin
                user_last = (idx == n_stream - 1);
                last = (k == nb - 1) || user_last;
                exp_q.push_back('{s_data[idx], s_keep[idx], last, 1'b0});
                idx++;
                if (last) begin
                    if (user_last) begin
                        ended = 1'b1;
                        err = (k != nb - 1) || (rem != pb);
                    end else if (rem == pb) begin
                        ended = 1'b1;
                        err = 1'b1;
                    end
                    break;
                end
            end
            model_tid++;
            a += 34'(pb);
            rem -= pb;
        end
        exp_done++;
        if (err) exp_err++;
    endtask

    task automatic applyStimulus(input logic [33:0] base, input int bytes, input int n_stream, input int abort_after);
        int wait_cyc;
        s_data.delete();
        s_keep.delete();
        for (int i = 0; i < n_stream; i++) begin
            s_data.push_back({$urandom, $urandom});
            s_keep.push_back(8'($urandom));
        end
        modelTransfer(base, bytes, n_stream);
        @(posedge log_clk);
        #1;
        for (int i = 0; i < n_stream; i++) begin
            if (abort_after != 0 && i == abort_after) break;
            if (valid_gaps) begin
                while ($urandom_range(0, 3) == 0) begin
                    user_tvalid_i = 1'b0;
                    @(posedge log_clk);
                    #1;
                end
            end
            user_tvalid_i = 1'b1;
            user_tfirst_i = (i == 0);
            user_tlast_i  = (i == n_stream - 1);
            user_tdata_i  = s_data[i];
            user_tkeep_i  = s_keep[i];
            user_addr_i   = (i == 0) ? base : 34'({$urandom, $urandom});
            user_tsize_i  = (i == 0) ? 20'(bytes - 1) : 20'($urandom);
            wait_cyc = 0;
            do begin
                @(negedge log_clk);
                wait_cyc++;
            end while (!user_tready_o && wait_cyc < 1000);
            if (!user_tready_o) begin
                failNow("user beat accept timeout");
                break;
            end
            @(posedge log_clk);
            #1;
        end
        user_tvalid_i = 1'b0;
        user_tfirst_i = 1'b0;
        user_tlast_i  = 1'b0;
    endtask

    task automatic waitDone();
        int cyc;
        cyc = 0;
        while ((exp_q.size() != 0 || done_count < exp_done) && cyc < 1000) begin
            @(negedge log_clk);
            cyc++;
        end
        if (exp_q.size() != 0 || done_count < exp_done) failNow("transfer completion timeout");
        repeat (3) @(negedge log_clk);
        checkOutput("done pulse count", 64'(done_count), 64'(exp_done));
        checkOutput("err pulse count", 64'(err_count), 64'(exp_err));
        checkOutput("nwr_ready after done", 64'(nwr_ready_o), 64'd1);
    endtask

    initial begin
        forever begin
            @(posedge log_clk);
            #1;
            ireq_tready_i = rdy_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: every ireq handshake must match the head of the expected queue.
    initial begin
        beat_t b;
        forever begin
            @(negedge log_clk);
            if (log_rst_n) begin
                if (nwr_done_o) done_count++;
                if (nwr_err_o) err_count++;
                if (ireq_tvalid_o && ireq_tready_i) begin
                    if (exp_q.size() == 0) begin
                        failNow("unexpected ireq beat");
                    end else begin
                        b = exp_q.pop_front();
                        checkOutput(b.hdr ? "header tdata" : "payload tdata", ireq_tdata_o, b.data);
                        checkOutput("ireq_tkeep", 64'(ireq_tkeep_o), 64'(b.keep));
                        checkOutput("ireq_tlast", 64'(ireq_tlast_o), 64'(b.last));
                        if (b.hdr) checkOutput("header tuser", 64'(ireq_tuser_o), 64'({SRC, DST}));
                    end
                end
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int bytes;
        int nb;
        int ns;
        int save_done;
        int save_err;

        repeat (3) @(negedge log_clk);
        checkOutput("reset ireq_tvalid", 64'(ireq_tvalid_o), 64'd0);
        checkOutput("reset user_tready", 64'(user_tready_o), 64'd0);
        checkOutput("reset busy", 64'(nwr_busy_o), 64'd0);
        checkOutput("reset done", 64'(nwr_done_o), 64'd0);
        checkOutput("reset err", 64'(nwr_err_o), 64'd0);
        checkOutput("reset ready link down", 64'(nwr_ready_o), 64'd0);
        link_ok_i = 1'b1;
        #1;
        checkOutput("reset ready link up", 64'(nwr_ready_o), 64'd1);
        @(posedge log_clk);
        #1;
        log_rst_n = 1'b1;

        // With the link down a first beat must not start a transfer.
        link_ok_i = 1'b0;
        user_tvalid_i = 1'b1;
        user_tfirst_i = 1'b1;
        repeat (4) @(negedge log_clk);
        checkOutput("link down ready", 64'(nwr_ready_o), 64'd0);
        checkOutput("link down ireq_tvalid", 64'(ireq_tvalid_o), 64'd0);
        checkOutput("link down user_tready", 64'(user_tready_o), 64'd0);
        user_tvalid_i = 1'b0;
        user_tfirst_i = 1'b0;
        link_ok_i = 1'b1;

        applyStimulus(34'h0_0000_1000, 256, 32, 0);
        waitDone();
        applyStimulus(34'h0_0000_1000, 1024, 128, 0);
        waitDone();
        applyStimulus(34'h2_0000_0000, 260, 33, 0);
        waitDone();
        rdy_random = 1'b1;
        applyStimulus(34'h0_0000_4000, 512, 64, 0);
        waitDone();
        rdy_random = 1'b0;
        applyStimulus(34'h0_0000_5000, 256, 10, 0);
        waitDone();
        applyStimulus(34'h0_0000_6000, 16, 4, 0);
        waitDone();
        applyStimulus(34'h3_FFFF_FF80, 300, 38, 0);
        waitDone();

        rdy_random = 1'b1;
        valid_gaps = 1'b1;
        for (int t = 0; t < 8; t++) begin
            bytes = $urandom_range(1, 700);
            nb = (bytes + 7) / 8;
            case ($urandom_range(0, 3))
                0:       ns = nb + $urandom_range(1, 3);
                1:       ns = $urandom_range(1, nb);
                default: ns = nb;
            endcase
            applyStimulus(34'({$urandom, $urandom}), bytes, ns, 0);
            waitDone();
        end

        // Reset in the middle of the second packet abandons the transfer.
        rdy_random = 1'b0;
        valid_gaps = 1'b0;
        save_done = exp_done;
        save_err = exp_err;
        applyStimulus(34'h0_0000_7000, 1024, 128, 37);
        checkOutput("busy mid-packet", 64'(nwr_busy_o), 64'd1);
        log_rst_n = 1'b0;
        #1;
        checkOutput("mid reset ireq_tvalid", 64'(ireq_tvalid_o), 64'd0);
        checkOutput("mid reset ireq_tlast", 64'(ireq_tlast_o), 64'd0);
        checkOutput("mid reset ireq_tdata", ireq_tdata_o, 64'd0);
        checkOutput("mid reset user_tready", 64'(user_tready_o), 64'd0);
        checkOutput("mid reset busy", 64'(nwr_busy_o), 64'd0);
        checkOutput("mid reset done", 64'(nwr_done_o), 64'd0);
        checkOutput("mid reset err", 64'(nwr_err_o), 64'd0);
        checkOutput("mid reset ready", 64'(nwr_ready_o), 64'd1);
        exp_q.delete();
        model_tid = 8'd0;
        exp_done = save_done;
        exp_err = save_err;
        repeat (2) @(posedge log_clk);
        #1;
        log_rst_n = 1'b1;
        applyStimulus(34'h0_0000_8000, 64, 8, 0);
        waitDone();

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/srio_nwr_packetizer.md
Name: srio_nwr_packetizer

Overview:
- Consumes the user NWRITE stream (address, size, 64-bit data beats) from the user-side data generator.
- Emits SRIO HELLO-format NWRITE request packets on the ireq AXI-Stream port of the SRIO logical layer.
- Splits a transfer into packets of at most MAX_PAYLOAD bytes. Prepends one header beat per packet, with address and TID advanced per packet.
- Drives the nwr_ready/busy/done handshake that the generator uses to pace transfers.

Parameters:
- MAX_PAYLOAD, 256, maximum payload bytes per SRIO packet; power of two, 8..256.
- PRIO, 2'd1, SRIO priority field.
- CRF, 1'b0, critical request flow bit.
- SRC_ID, 16'h0000, source device ID placed in ireq_tuser[31:16].
- DEST_ID, 16'h0000, destination device ID placed in ireq_tuser[15:0].

Ports:
- log_clk  in  1  logical-layer clock.
- log_rst_n  in  1  asynchronous active-low reset.
- link_ok_i  in  1  SRIO link/port initialised.
- nwr_ready_o  out  1  idle and link up; a transfer may start.
- nwr_busy_o  out  1  transfer in progress.
- nwr_done_o  out  1  one-cycle pulse at transfer end.
- nwr_err_o  out  1  one-cycle pulse when the length does not match the user_tlast position.
- user_addr_i  in  34  transfer base byte address; sampled on the first beat.
- user_tsize_i  in  20  transfer bytes minus 1; sampled on the first beat.
- user_tdata_i  in  64  payload beat.
- user_tkeep_i  in  8  byte enables.
- user_tfirst_i  in  1  first beat of a transfer.
- user_tvalid_i  in  1  beat valid.
- user_tlast_i  in  1  last beat of a transfer.
- user_tready_o  out  1  beat accepted when it is high together with user_tvalid_i.
- ireq_tdata_o  out  64  header or payload beat.
- ireq_tkeep_o  out  8  byte enables; 8'hff on the header beat.
- ireq_tlast_o  out  1  last beat of the packet.
- ireq_tuser_o  out  32  {SRC_ID, DEST_ID}; valid on the header beat.
- ireq_tvalid_o  out  1  beat valid.
- ireq_tready_i  in  1  downstream ready.

Behaviour:
- Reset (async, log_rst_n=0):
  - state=IDLE; tid=0; all counters=0.
  - All outputs 0, except nwr_ready_o, which follows link_ok_i once in IDLE.
- Reset mid-packet: the packet is abandoned with no tlast and no done/err pulse.
- Header beat layout:
  - [63:56] tid
  - [55:52] ftype=4'h5
  - [51:48] ttype=4'h4
  - [47]=0
  - [46:45] PRIO
  - [44] CRF
  - [43:36] pkt_bytes-1
  - [35:34]=0
  - [33:0] pkt_addr
- Remaining-byte count: rem, 21 bits = user_tsize_i+1.
- Packet size: pkt_bytes = min(rem, MAX_PAYLOAD). Packet beats = ceil(pkt_bytes/8).
- IDLE:
  - nwr_ready_o = link_ok_i.
  - user_tready_o=0.
  - On user_tvalid_i & user_tfirst_i & link_ok_i: latch addr and rem, go to HDR. The beat is not consumed.
- HDR:
  - ireq_tvalid_o=1; data = header; ireq_tlast_o=0; user_tready_o=0; nwr_busy_o=1.
  - On ireq_tready_i: go to DATA.
- DATA (zero-latency pass-through):
  - ireq_tvalid_o=user_tvalid_i; user_tready_o=ireq_tready_i.
  - tdata and tkeep pass through.
  - A beat transfers when user_tvalid_i & ireq_tready_i.
  - ireq_tlast_o is high on the last packet beat, or on user_tlast_i, whichever comes first.
  - On the transferred tlast beat:
    - rem -= pkt_bytes; addr += pkt_bytes (34-bit wrap); tid += 1 (8-bit wrap 255->0).
    - Normal end (count exhausted and user_tlast_i): go to DONE.
    - Count not exhausted and no user_tlast_i: go to HDR for the next packet.
    - user_tlast_i early (rem not exhausted): nwr_err_o pulses, go to DONE.
    - Count exhausted but no user_tlast_i: nwr_err_o pulses, go to DRAIN.
- DRAIN:
  - user_tready_o=1; ireq_tvalid_o=0; beats are discarded.
  - On user_tvalid_i & user_tlast_i: go to DONE.
- DONE: nwr_done_o=1 for one cycle, then go to IDLE.
- user_tfirst_i is ignored outside IDLE.
- user_tkeep_i is not checked against the size.
- No response tracking; NWRITE carries no response.

Decomposition:
- Shared package srio_pkg:
  - FTYPE_NWRITE=4'h5, TTYPE_NWRITE=4'h4.
  - HELLO header field offsets.
  - State enum {IDLE, HDR, DATA, DRAIN, DONE}.
- Optional sub-module srio_hello_hdr: combinational header packer (tid, prio, crf, size, addr -> 64 bits), reusable by NREAD/SWRITE initiators.

Test Plan:
- 256-byte transfer (user_tsize_i=255), addr 0x0_0000_1000 -> 1 header with size field 8'hff, tid 0, addr 0x1000, then 32 data beats with tlast on beat 32; nwr_done_o pulses once.
- 1024-byte transfer -> 4 packets, tid 0..3, addrs 0x1000/0x1100/0x1200/0x1300, each 33 beats; one done pulse.
- 260-byte transfer -> packet 1: 256 bytes; packet 2: header size field 8'h03, addr base+0x100, 1 data beat carrying user tkeep, with tlast.
- Random ireq_tready_i deassertion (50%) on a 512-byte transfer -> data identical and in order, no beat lost or duplicated, user_tready_o mirrors ireq_tready_i in DATA.
- Error cases:
  - user_tlast_i on beat 10 of a declared 256-byte transfer -> ireq_tlast_o on beat 10, nwr_err_o and nwr_done_o each pulse.
  - 16-byte declared transfer with a 4-beat stream -> tlast on beat 2, then 2 beats drained, err pulse.
- log_rst_n asserted mid-DATA of packet 2 -> all outputs 0 immediately; after release, a new transfer starts with tid 0.
